bsg_manycore_link_to_cce_mem: RTL and testbench
===============================================

BSG_MANYCORE_LINK_TO_CCE_MEM -- requirements
Module: bsg_manycore_link_to_cce_mem

Interface
REQ-001 SHALL have parameter link_data_width_p, default 32, manycore word width; multiple of 8.
REQ-002 SHALL have parameter link_addr_width_p, default 28, manycore word-address width.
REQ-003 SHALL have parameters x_cord_width_p (default 4), y_cord_width_p (default 4) and load_id_width_p (default 11), the manycore packet fields.
REQ-004 SHALL have parameter bp_addr_width_p, default 39, CCE byte-address width.
REQ-005 SHALL have parameter block_size_in_bits_p, default 512, cache block width; N = block_size_in_bits_p/link_data_width_p, a power of two.
REQ-006 SHALL have parameter tag_width_p, default 8, opaque command tag width, echoed on the response.
REQ-007 SHALL have parameter max_outstanding_p, default 4, pending-command queue depth.
REQ-008 SHALL have port clk_i, in, 1, clock.
REQ-009 SHALL have port reset_n_i, in, 1, asynchronous active-low reset.
REQ-010 SHALL have ports cmd_v_i (in, 1) and cmd_ready_o (out, 1), the command valid/ready handshake.
REQ-011 SHALL have command payload inputs: cmd_write_i (1), cmd_uncached_i (1), cmd_addr_i (bp_addr_width_p), cmd_data_i (block_size_in_bits_p), cmd_tag_i (tag_width_p).
REQ-012 SHALL have ports resp_v_o (out, 1) and resp_ready_i (in, 1), the response valid/ready handshake.
REQ-013 SHALL have response payload outputs: resp_write_o (1), resp_uncached_o (1), resp_addr_o (bp_addr_width_p), resp_data_o (block_size_in_bits_p), resp_tag_o (tag_width_p).
REQ-014 SHALL have ports pkt_o (out, manycore packet width), pkt_v_o (out, 1) and pkt_yumi_i (in, 1), the outgoing manycore request.
REQ-015 SHALL have ports returned_data_i (in, link_data_width_p), returned_v_i (in, 1) and returned_yumi_o (out, 1), in-order load return data.
REQ-016 SHALL have ports my_x_i (in, x_cord_width_p) and my_y_i (in, y_cord_width_p), own tile coordinates.

Function
REQ-017 SHALL accept a command when cmd_v_i & cmd_ready_o; cmd_ready_o = (tx_state==IDLE) & pending-queue not full.
REQ-018 SHALL, on acceptance, push {write, uncached, addr, tag} into the pending queue, register addr/data/flags, and go to SEND.
REQ-019 SHALL issue F packets per command: F=N for cached commands, F=1 for uncached; flit index k counts 0..F-1, advancing only on pkt_yumi_i.
REQ-020 SHALL hold pkt_v_o=1 in SEND only, and return to IDLE the cycle after the yumi of flit F-1.
REQ-021 SHALL set packet op to remote_store for writes (payload = data word k; word 0 for uncached) and remote_load for reads (payload 0); op_ex = all ones.
REQ-022 SHALL form the cached address as {0, addr[byte_off+lgN +: link_addr_width_p-lgN-1], k}; uncached as {0, addr[byte_off +: link_addr_width_p-1]}.
REQ-023 SHALL set x_cord = addr[byte_off+link_addr_width_p-1 +: x_cord_width_p], y_cord = my_y_i+1 truncated, src = my_x_i/my_y_i.
REQ-024 SHALL assemble return words into a block buffer at index rc (0..F-1) of the queue head, with returned_yumi_o = returned_v_i & head is read & rc<F.
REQ-025 SHALL raise resp_v_o when the queue head is a write whose packets have all been yumi'd, or a read with rc==F; responses are issued strictly in command order.
REQ-026 SHALL drive uncached read data in the low link_data_width_p bits of resp_data_o, zero-extended; write responses carry resp_data_o=0.
REQ-027 SHALL pop the head and clear rc on resp_v_o & resp_ready_i; while resp_ready_i=0, returned data beyond rc==F is back-pressured.
REQ-028 SHALL permit, in the same cycle, a command accept and a response pop; a full queue with a simultaneous pop keeps cmd_ready_o=0 for that cycle.

Reset
REQ-029 SHALL, while reset_n_i=0, clear tx state to IDLE, the flit counters and queue pointers, and drive cmd_ready_o=0, pkt_v_o=0, resp_v_o=0, returned_yumi_o=0; mid-packet reset discards all in-flight commands.

Structure
REQ-030 SHALL keep the tx state enum and the response-command struct in bsg_manycore_link_to_cce_pkg.
REQ-031 SHALL use bsg_fifo_1r1w_small (els_p=max_outstanding_p) as the pending queue; no other sub-modules.

Verification (link_data_width_p=32, block 512, N=16)
REQ-032 Cached read at addr 0x1_0040 -> 16 remote_load packets with addresses ascending by 1; 16 returned words -> one response with words in order, matching tag.
REQ-033 Cached write with data word k = k -> 16 remote_store packets with payload 0..15; write response follows the last yumi, resp_data_o=0.
REQ-034 Uncached read -> 1 packet; returned 0xDEADBEEF -> resp_data_o = 0x...0DEADBEEF.
REQ-035 Issue 4 reads back-to-back with resp_ready_i=0 -> cmd_ready_o drops after the 4th; raise resp_ready_i -> tags return in order 0,1,2,3.
REQ-036 Write then read, with pkt_yumi_i toggling at random -> responses ordered write then read, no flit lost or duplicated.
REQ-037 Assert reset_n_i during flit 7 of a read -> all outputs 0 immediately; after release a new command completes normally.

Source files
------------

// File: rtl/bsg_manycore_link_to_cce_pkg.sv
// Shared types for the manycore-link to CCE memory bridge.
package bsg_manycore_link_to_cce_pkg;

    // Transmit side: idle waiting for a command, or streaming its flits.
    typedef enum logic {
        e_tx_idle = 1'b0,
        e_tx_send = 1'b1
    } tx_state_e;

    // Pending-command record kept until the response is consumed.
    // Fields are sized for the widest supported configuration and
    // narrowed to the module parameters at the point of use.
    typedef struct packed {
        logic        write;
        logic        uncached;
        logic [63:0] addr;
        logic [31:0] tag;
    } resp_cmd_s;

    // Manycore packet opcodes.
    localparam logic [1:0] remote_load_op  = 2'b00;
    localparam logic [1:0] remote_store_op = 2'b01;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with valid/ready in and valid/yumi out.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rptr_r, wptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                push, pop;

    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign ready_o = (cnt_r != cnt_w_lp'(els_p));
    assign v_o     = (cnt_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_r <= '0;
            wptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (push) wptr_r <= bump(wptr_r);
            if (pop)  rptr_r <= bump(rptr_r);
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + cnt_w_lp'(1);
                2'b01:   cnt_r <= cnt_r - cnt_w_lp'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Storage array, written on every accepted push.
    always_ff @(posedge clk_i) begin
        if (push) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_link_to_cce_mem.sv
// Bridges CCE block commands onto manycore word packets and reassembles
// in-order load returns into block responses, issued in command order.
module bsg_manycore_link_to_cce_mem
    import bsg_manycore_link_to_cce_pkg::*;
#(
    parameter int unsigned link_data_width_p    = 32,
    parameter int unsigned link_addr_width_p    = 28,
    parameter int unsigned x_cord_width_p       = 4,
    parameter int unsigned y_cord_width_p       = 4,
    parameter int unsigned load_id_width_p      = 11,
    parameter int unsigned bp_addr_width_p      = 39,
    parameter int unsigned block_size_in_bits_p = 512,
    parameter int unsigned tag_width_p          = 8,
    parameter int unsigned max_outstanding_p    = 4,
    localparam int unsigned pkt_width_lp = link_addr_width_p + 2 + link_data_width_p/8
                                         + link_data_width_p + 2*x_cord_width_p + 2*y_cord_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            cmd_v_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic                            cmd_uncached_i,
    input  logic [bp_addr_width_p-1:0]      cmd_addr_i,
    input  logic [block_size_in_bits_p-1:0] cmd_data_i,
    input  logic [tag_width_p-1:0]          cmd_tag_i,
    output logic                            resp_v_o,
    input  logic                            resp_ready_i,
    output logic                            resp_write_o,
    output logic                            resp_uncached_o,
    output logic [bp_addr_width_p-1:0]      resp_addr_o,
    output logic [block_size_in_bits_p-1:0] resp_data_o,
    output logic [tag_width_p-1:0]          resp_tag_o,
    output logic [pkt_width_lp-1:0]         pkt_o,
    output logic                            pkt_v_o,
    input  logic                            pkt_yumi_i,
    input  logic [link_data_width_p-1:0]    returned_data_i,
    input  logic                            returned_v_i,
    output logic                            returned_yumi_o,
    input  logic [x_cord_width_p-1:0]       my_x_i,
    input  logic [y_cord_width_p-1:0]       my_y_i
);

    localparam int unsigned n_lp        = block_size_in_bits_p / link_data_width_p;
    localparam int unsigned lg_n_lp     = $clog2(n_lp);
    localparam int unsigned k_w_lp      = (lg_n_lp > 0) ? lg_n_lp : 1;
    localparam int unsigned rc_w_lp     = lg_n_lp + 1;
    localparam int unsigned byte_off_lp = $clog2(link_data_width_p / 8);
    localparam int unsigned sent_w_lp   = $clog2(max_outstanding_p + 1);

    tx_state_e                     state_r, state_n;
    logic [k_w_lp-1:0]             k_r, k_n;
    logic                          write_r, uncached_r;
    logic [bp_addr_width_p-1:0]    addr_r;
    logic [block_size_in_bits_p-1:0] data_r, blk_r;
    logic [rc_w_lp-1:0]            rc_r, head_f;
    logic [sent_w_lp-1:0]          sent_r;
    logic                          fifo_ready, fifo_v;
    resp_cmd_s                     push_cmd, head;
    logic                          cmd_accept, last_flit, send_done, rc_full, resp_pop;
    logic [load_id_width_p-1:0]    load_id;
    logic [link_addr_width_p-1:0]  word_addr;
    logic [link_data_width_p-1:0]  payload;

    assign cmd_ready_o = reset_n_i & (state_r == e_tx_idle) & fifo_ready;
    assign cmd_accept  = cmd_v_i & cmd_ready_o;
    assign last_flit   = uncached_r | (k_r == k_w_lp'(n_lp - 1));
    assign send_done   = pkt_v_o & pkt_yumi_i & last_flit;
    assign load_id     = '0;

    assign push_cmd = '{write: cmd_write_i, uncached: cmd_uncached_i,
                        addr: 64'(cmd_addr_i), tag: 32'(cmd_tag_i)};

    bsg_fifo_1r1w_small #(
        .width_p($bits(resp_cmd_s)),
        .els_p  (max_outstanding_p)
    ) pending_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (cmd_accept),
        .ready_o  (fifo_ready),
        .data_i   (push_cmd),
        .v_o      (fifo_v),
        .data_o   (head),
        .yumi_i   (resp_pop)
    );

    // Transmit FSM: next state, flit index and packet valid.
    always_comb begin
        state_n = state_r;
        k_n     = k_r;
        pkt_v_o = 1'b0;
        case (state_r)
            e_tx_idle: begin
                if (cmd_accept) begin
                    state_n = e_tx_send;
                    k_n     = '0;
                end
            end
            e_tx_send: begin
                pkt_v_o = 1'b1;
                if (pkt_yumi_i) begin
                    if (last_flit) state_n = e_tx_idle;
                    else           k_n     = k_r + k_w_lp'(1);
                end
            end
            default: state_n = e_tx_idle;
        endcase
    end

    // Transmit FSM state and flit index registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_tx_idle;
            k_r     <= '0;
        end else begin
            state_r <= state_n;
            k_r     <= k_n;
        end
    end

    // Capture the accepted command for the duration of its packets.
    always_ff @(posedge clk_i) begin
        if (cmd_accept) begin
            write_r    <= cmd_write_i;
            uncached_r <= cmd_uncached_i;
            addr_r     <= cmd_addr_i;
            data_r     <= cmd_data_i;
        end
    end

    // Outgoing packet fields derived from the captured command and flit index.
    always_comb begin
        if (uncached_r)
            word_addr = {1'b0, addr_r[byte_off_lp +: link_addr_width_p-1]};
        else
            word_addr = {1'b0, addr_r[byte_off_lp+lg_n_lp +: link_addr_width_p-lg_n_lp-1], k_r};
        payload = write_r ? data_r[32'(k_r)*link_data_width_p +: link_data_width_p]
                          : link_data_width_p'(load_id);
        pkt_o = {word_addr,
                 write_r ? remote_store_op : remote_load_op,
                 {(link_data_width_p/8){1'b1}},
                 payload,
                 my_y_i, my_x_i,
                 my_y_i + y_cord_width_p'(1),
                 addr_r[byte_off_lp+link_addr_width_p-1 +: x_cord_width_p]};
    end

    // A queued write is complete once all its flits left; since commands are
    // sent strictly in order, counting finished-but-unpopped commands suffices.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_r <= '0;
        end else begin
            case ({send_done, resp_pop})
                2'b10:   sent_r <= sent_r + sent_w_lp'(1);
                2'b01:   sent_r <= sent_r - sent_w_lp'(1);
                default: sent_r <= sent_r;
            endcase
        end
    end

    assign head_f          = head.uncached ? rc_w_lp'(1) : rc_w_lp'(n_lp);
    assign rc_full         = (rc_r == head_f);
    assign returned_yumi_o = returned_v_i & fifo_v & ~head.write & ~rc_full;
    assign resp_v_o        = fifo_v & (head.write ? (sent_r != '0) : rc_full);
    assign resp_pop        = resp_v_o & resp_ready_i;

    // Assemble returned load words into the block buffer for the queue head.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rc_r  <= '0;
            blk_r <= '0;
        end else if (resp_pop) begin
            rc_r  <= '0;
            blk_r <= '0;
        end else if (returned_yumi_o) begin
            blk_r[32'(rc_r)*link_data_width_p +: link_data_width_p] <= returned_data_i;
            rc_r <= rc_r + rc_w_lp'(1);
        end
    end

    assign resp_write_o    = head.write;
    assign resp_uncached_o = head.uncached;
    assign resp_addr_o     = bp_addr_width_p'(head.addr);
    assign resp_tag_o      = tag_width_p'(head.tag);
    assign resp_data_o     = head.write ? '0 : blk_r;

endmodule

// File: tb/tb_bsg_manycore_link_to_cce_mem.sv
// Scoreboard bench: commands push expected packets/responses, monitors compare.
module tb_bsg_manycore_link_to_cce_mem;

    localparam int W = 32, BLK = 512, N = 16, AW = 39, TW = 8, PW = 82;

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic            cmd_v_i, cmd_ready_o, cmd_write_i, cmd_uncached_i;
    logic [AW-1:0]   cmd_addr_i;
    logic [BLK-1:0]  cmd_data_i;
    logic [TW-1:0]   cmd_tag_i;
    logic            resp_v_o, resp_ready_i, resp_write_o, resp_uncached_o;
    logic [AW-1:0]   resp_addr_o;
    logic [BLK-1:0]  resp_data_o;
    logic [TW-1:0]   resp_tag_o;
    logic [PW-1:0]   pkt_o;
    logic            pkt_v_o, pkt_yumi_i;
    logic [W-1:0]    returned_data_i;
    logic            returned_v_i, returned_yumi_o;
    logic [3:0]      my_x, my_y;

    assign my_x = 4'd3;
    assign my_y = 4'd15;

    always #5 clk = ~clk;

    bsg_manycore_link_to_cce_mem #(
        .link_data_width_p(W), .link_addr_width_p(28), .x_cord_width_p(4),
        .y_cord_width_p(4), .load_id_width_p(11), .bp_addr_width_p(AW),
        .block_size_in_bits_p(BLK), .tag_width_p(TW), .max_outstanding_p(4)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_uncached_i(cmd_uncached_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .cmd_tag_i(cmd_tag_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_write_o(resp_write_o),
        .resp_uncached_o(resp_uncached_o), .resp_addr_o(resp_addr_o),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o),
        .pkt_o(pkt_o), .pkt_v_o(pkt_v_o), .pkt_yumi_i(pkt_yumi_i),
        .returned_data_i(returned_data_i), .returned_v_i(returned_v_i),
        .returned_yumi_o(returned_yumi_o),
        .my_x_i(my_x), .my_y_i(my_y)
    );

    typedef struct {
        logic [PW-1:0] pkt;
        logic          is_load;
        logic [31:0]   ret;
    } exp_pkt_t;

    typedef struct {
        logic          write;
        logic          uncached;
        logic [AW-1:0] addr;
        logic [BLK-1:0] data;
        logic [TW-1:0] tag;
    } exp_resp_t;

    exp_pkt_t  pkt_q[$];
    exp_resp_t resp_q[$];
    logic [31:0] ret_q[$];
    exp_pkt_t  mon_p;
    exp_resp_t mon_r;

    int tests = 0;
    int fails = 0;
    int flit_cnt = 0;
    int yumi_mode = 1;   // 1: always accept flits, 2: random
    int resp_mode = 1;   // 0: never ready, 1: always ready, 2: random

    // Reference packet: word address, opcode, byte mask, payload and routing.
    function automatic logic [PW-1:0] model_pkt(input logic write, input logic uncached,
                                                 input logic [AW-1:0] addr,
                                                 input logic [31:0] payload, input int k);
        logic [63:0] wa;
        logic [27:0] a;
        logic [3:0]  x;
        logic [3:0]  y;
        wa = 64'(addr) >> 2;
        if (uncached) a = 28'(wa % (64'd1 << 27));
        else          a = 28'(((wa >> 4) % (64'd1 << 23)) * 64'd16 + 64'(k));
        x = 4'((64'(addr) >> 29) % 64'd16);
        y = 4'((32'(my_y) + 32'd1) % 32'd16);
        return {a, (write ? 2'd1 : 2'd0), 4'hF, payload, my_y, my_x, y, x};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present one command (entered and left at posedge+1) and record expectations.
    task automatic issue(input logic write, input logic uncached, input logic [AW-1:0] addr,
                         input logic [BLK-1:0] data, input logic [TW-1:0] tag,
                         input logic fixed, input logic [31:0] fixed_word);
        logic [31:0] words [N];
        exp_pkt_t    p;
        exp_resp_t   r;
        int          f;
        int          bound;
        f = uncached ? 1 : N;
        for (int k = 0; k < N; k++) words[k] = fixed ? fixed_word + 32'(k) : $urandom;
        cmd_v_i = 1'b1; cmd_write_i = write; cmd_uncached_i = uncached;
        cmd_addr_i = addr; cmd_data_i = data; cmd_tag_i = tag;
        bound = 0;
        do begin
            @(negedge clk);
            bound++;
        end while (!cmd_ready_o && bound < 4000);
        tests++;
        if (!cmd_ready_o) begin
            fails++;
            $display("FAIL cmd_accept got=ready0 expected=ready1 tag=%0h", tag);
        end else begin
            for (int k = 0; k < f; k++) begin
                p.pkt     = model_pkt(write, uncached, addr, write ? data[k*32 +: 32] : 32'd0, k);
                p.is_load = !write;
                p.ret     = words[k];
                pkt_q.push_back(p);
            end
            r.write = write; r.uncached = uncached; r.addr = addr; r.tag = tag; r.data = '0;
            if (!write) for (int k = 0; k < f; k++) r.data[k*32 +: 32] = words[k];
            resp_q.push_back(r);
        end
        @(posedge clk); #1;
        cmd_v_i = 1'b0;
    endtask

    // Wait for every expected packet and response to be observed.
    task automatic drain(input int bound);
        int c = 0;
        while ((pkt_q.size() != 0 || resp_q.size() != 0) && c < bound) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (pkt_q.size() != 0 || resp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=pkts%0d/resps%0d expected=0/0", pkt_q.size(), resp_q.size());
            pkt_q.delete(); resp_q.delete(); ret_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Packet monitor: every accepted flit must match the next expected one.
    always @(negedge clk) begin
        if (reset_n_i && pkt_v_o && pkt_yumi_i) begin
            flit_cnt++;
            tests++;
            if (pkt_q.size() == 0) begin
                fails++;
                $display("FAIL pkt_extra got=%h expected=none", pkt_o);
            end else begin
                mon_p = pkt_q.pop_front();
                if (pkt_o !== mon_p.pkt) begin
                    fails++;
                    $display("FAIL pkt got=%h expected=%h", pkt_o, mon_p.pkt);
                end
                if (mon_p.is_load) ret_q.push_back(mon_p.ret);
            end
        end
    end

    // Response monitor: responses must appear in issue order with correct contents.
    always @(negedge clk) begin
        if (reset_n_i && resp_v_o && resp_ready_i) begin
            if (resp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL resp_extra got=tag%0h expected=none", resp_tag_o);
            end else begin
                mon_r = resp_q.pop_front();
                tests++;
                if (resp_tag_o !== mon_r.tag) begin
                    fails++;
                    $display("FAIL resp_tag got=%0h expected=%0h", resp_tag_o, mon_r.tag);
                end
                tests++;
                if ({resp_write_o, resp_uncached_o, resp_addr_o, resp_data_o} !==
                    {mon_r.write, mon_r.uncached, mon_r.addr, mon_r.data}) begin
                    fails++;
                    $display("FAIL resp_body got=%h expected=%h",
                             {resp_write_o, resp_uncached_o, resp_addr_o, resp_data_o},
                             {mon_r.write, mon_r.uncached, mon_r.addr, mon_r.data});
                end
            end
        end
    end

    // Load-return source: replays memory words in the order loads were issued.
    initial begin
        returned_v_i = 1'b0;
        returned_data_i = '0;
        forever begin
            @(posedge clk); #1;
            if (reset_n_i && ret_q.size() > 0 && $urandom_range(3) != 0) begin
                returned_v_i    = 1'b1;
                returned_data_i = ret_q[0];
            end else begin
                returned_v_i = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (returned_v_i && returned_yumi_o) void'(ret_q.pop_front());
    end

    // Flit acceptance and response readiness drivers.
    initial begin
        pkt_yumi_i = 1'b0;
        resp_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            pkt_yumi_i   = reset_n_i && pkt_v_o && (yumi_mode == 1 || $urandom_range(1) == 1);
            resp_ready_i = (resp_mode == 2) ? ($urandom_range(1) == 1) : (resp_mode == 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BLK-1:0] d;
        logic [AW-1:0]  a;
        int             c;
        int             base;

        reset_n_i = 1'b0; cmd_v_i = 1'b0; cmd_write_i = 1'b0; cmd_uncached_i = 1'b0;
        cmd_addr_i = '0; cmd_data_i = '0; cmd_tag_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 0);
        chk("rst_pkt_v", 64'(pkt_v_o), 0);
        chk("rst_resp_v", 64'(resp_v_o), 0);
        chk("rst_returned_yumi", 64'(returned_yumi_o), 0);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(cmd_ready_o), 1);

        // Cached read at a fixed address.
        issue(1'b0, 1'b0, 39'h1_0040, '0, 8'h11, 1'b0, 32'd0);
        drain(2000);

        // Cached write whose word k carries k.
        for (int k = 0; k < N; k++) d[k*32 +: 32] = 32'(k);
        issue(1'b1, 1'b0, AW'({$urandom, $urandom}), d, 8'h22, 1'b0, 32'd0);
        drain(2000);

        // Uncached read and uncached write.
        issue(1'b0, 1'b1, AW'({$urandom, $urandom}), '0, 8'h33, 1'b1, 32'hDEADBEEF);
        drain(2000);
        for (int k = 0; k < N; k++) d[k*32 +: 32] = $urandom;
        issue(1'b1, 1'b1, AW'({$urandom, $urandom}), d, 8'h34, 1'b0, 32'd0);
        drain(2000);

        // Fill the pending queue with responses blocked.
        resp_mode = 0;
        for (int t = 0; t < 4; t++) issue(1'b0, 1'b0, AW'({$urandom, $urandom}), '0, 8'(t), 1'b0, 32'd0);
        c = 0;
        while (pkt_q.size() != 0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        repeat (20) @(negedge clk);
        chk("full_cmd_ready", 64'(cmd_ready_o), 0);
        chk("full_resp_v", 64'(resp_v_o), 1);
        @(posedge clk); #1;
        resp_mode = 1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(resp_v_o && resp_ready_i) && c < 100);
        chk("pop_full_cmd_ready", 64'(cmd_ready_o), 0);
        @(negedge clk);
        chk("ready_after_pop", 64'(cmd_ready_o), 1);
        @(posedge clk); #1;
        drain(4000);

        // Write then read of the same block with irregular flit acceptance.
        yumi_mode = 2;
        a = AW'({$urandom, $urandom});
        for (int k = 0; k < N; k++) d[k*32 +: 32] = $urandom;
        issue(1'b1, 1'b0, a, d, 8'h44, 1'b0, 32'd0);
        issue(1'b0, 1'b0, a, '0, 8'h45, 1'b0, 32'd0);
        drain(4000);

        // Random mix with random response back-pressure.
        resp_mode = 2;
        repeat (12) begin
            for (int k = 0; k < N; k++) d[k*32 +: 32] = $urandom;
            issue(1'($urandom), 1'($urandom), AW'({$urandom, $urandom}), d, 8'($urandom), 1'b0, 32'd0);
        end
        drain(20000);
        yumi_mode = 1;
        resp_mode = 1;

        // Reset during flit 7 of a cached read.
        base = flit_cnt;
        issue(1'b0, 1'b0, AW'({$urandom, $urandom}), '0, 8'h66, 1'b0, 32'd0);
        c = 0;
        while ((flit_cnt - base) < 7 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk); #1;
        chk("pkt_v_mid_packet", 64'(pkt_v_o), 1);
        #1;
        reset_n_i = 1'b0;
        #1;
        chk("midrst_pkt_v", 64'(pkt_v_o), 0);
        chk("midrst_resp_v", 64'(resp_v_o), 0);
        chk("midrst_cmd_ready", 64'(cmd_ready_o), 0);
        chk("midrst_returned_yumi", 64'(returned_yumi_o), 0);
        repeat (2) @(negedge clk);
        pkt_q.delete(); resp_q.delete(); ret_q.delete();
        reset_n_i = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 1'b1, AW'({$urandom, $urandom}), '0, 8'h77, 1'b1, 32'hCAFE0001);
        issue(1'b0, 1'b0, AW'({$urandom, $urandom}), '0, 8'h78, 1'b0, 32'd0);
        drain(4000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
